// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one SRAM-like memory port between icache refills
// and dcache refills/writebacks, issuing each miss as a line-aligned word burst.
module cache_mem_arbiter #(
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_rvalid,
    output logic [31:0] ic_rdata,
    output logic        ic_done,
    input  logic        dc_req,
    input  logic        dc_wr,
    input  logic [31:0] dc_addr,
    input  logic [31:0] dc_wdata,
    output logic        dc_wready,
    output logic        dc_rvalid,
    output logic [31:0] dc_rdata,
    output logic        dc_done,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ADDR    = 2'd1;
    localparam logic [1:0] S_DATA    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    localparam logic [31:0]      LINE_MASK = ~((32'(BURST_LEN) << 2) - 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_LEN - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_owner;
    logic             r_owner;
    logic             r_wr;
    logic [31:0]      r_base;

    logic             w_any_req;
    logic             w_grant_dc;
    logic             w_in_addr;
    logic             w_data_ok;
    logic             w_last;
    logic             w_done;

    // On a tie the requester that did not own the previous burst wins.
    assign w_any_req  = ic_req | dc_req;
    assign w_grant_dc = dc_req & (~ic_req | (r_last_owner == OWN_IC));

    assign w_in_addr = (r_state == S_ADDR);
    // Gating with rst keeps a completion from leaking out in the reset cycle.
    assign w_data_ok = (r_state == S_DATA) & mem_data_ok & rst;
    assign w_last    = (r_cnt == CNT_LAST);
    assign w_done    = w_data_ok & w_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_owner <= OWN_IC;
            r_owner      <= OWN_IC;
            r_wr         <= 1'b0;
            r_base       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant_dc ? OWN_DC : OWN_IC;
                        r_wr    <= w_grant_dc & dc_wr;
                        r_base  <= (w_grant_dc ? dc_addr : ic_addr) & LINE_MASK;
                        r_cnt   <= '0;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (mem_addr_ok) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (mem_data_ok) begin
                        if (w_last) begin
                            r_last_owner <= r_owner;
                            r_state      <= S_RELEASE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= S_ADDR;
                        end
                    end
                end
                S_RELEASE: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // The word offset is ORed into the cleared low bits, so it never carries out of the line.
    assign mem_req   = w_in_addr;
    assign mem_wr    = w_in_addr & r_wr;
    assign mem_addr  = w_in_addr ? (r_base | {{(30 - CNT_W){1'b0}}, r_cnt, 2'b00}) : 32'd0;
    assign mem_wdata = w_in_addr ? dc_wdata : 32'd0;

    assign ic_rdata  = mem_rdata;
    assign dc_rdata  = mem_rdata;

    assign ic_rvalid = w_data_ok & (r_owner == OWN_IC) & ~r_wr;
    assign ic_done   = w_done & (r_owner == OWN_IC);
    assign dc_rvalid = w_data_ok & (r_owner == OWN_DC) & ~r_wr;
    assign dc_wready = w_data_ok & (r_owner == OWN_DC) & r_wr;
    assign dc_done   = w_done & (r_owner == OWN_DC);

endmodule
